// File: rtl/shift_pkg.sv
// Shared types for the sequential shift/rotate unit.
package shift_pkg;

  // Operation select; encodings 101-111 are reserved and act as pass-through.
  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_mode_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } shift_state_t;

  // True for any encoding that names a real operation.
  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m <= 3'b100);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: next register value and the bit that leaves it.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  shift_mode_t    mode,
  input  logic [N-1:0]   din,
  output logic [N-1:0]   dout,
  output logic           bit_out
);

  // Single-position move per mode; reserved modes pass the operand through.
  always_comb begin
    dout    = din;
    bit_out = 1'b0;
    case (mode)
      SLL: begin
        dout    = {din[N-2:0], 1'b0};
        bit_out = din[N-1];
      end
      SRL: begin
        dout    = {1'b0, din[N-1:1]};
        bit_out = din[0];
      end
      SRA: begin
        dout    = {din[N-1], din[N-1:1]};
        bit_out = din[0];
      end
      ROL: begin
        dout    = {din[N-2:0], din[N-1]};
        bit_out = din[N-1];
      end
      ROR: begin
        dout    = {din[0], din[N-1:1]};
        bit_out = din[0];
      end
      default: begin
        dout    = din;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: captures an operand, then moves it one bit per clock.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    MODE,
  input  logic [AW-1:0] AMT,
  input  logic [N-1:0]  DIN,
  output logic [N-1:0]  Y,
  output logic          BUSY,
  output logic          DONE,
  output logic          CARRY
);

  shift_state_t  state_q, state_d;
  shift_mode_t   mode_q, mode_d;
  logic [N-1:0]  y_q, y_d;
  logic [AW-1:0] count_q, count_d;
  logic          carry_q, carry_d;

  logic [N-1:0]  step_y;
  logic          step_bit;
  logic          capture;

  shift_step #(.N(N)) u_step (
    .mode    (mode_q),
    .din     (y_q),
    .dout    (step_y),
    .bit_out (step_bit)
  );

  // A new operation is accepted whenever the unit is not mid-shift.
  assign capture = START && (state_q != SHIFT);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          if ((AMT != '0) && mode_is_valid(MODE)) begin
            state_d = SHIFT;
          end else begin
            state_d = FINISH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (count_q == AW'(1)) begin
          state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode_q  <= SLL;
      y_q     <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      y_q     <= y_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  // Datapath update: load on capture, step while shifting, hold otherwise.
  always_comb begin
    mode_d  = mode_q;
    y_d     = y_q;
    count_d = count_q;
    carry_d = carry_q;
    if (capture) begin
      mode_d  = shift_mode_t'(MODE);
      y_d     = DIN;
      count_d = AMT;
      carry_d = 1'b0;
    end else if (state_q == SHIFT) begin
      y_d     = step_y;
      carry_d = step_bit;
      count_d = count_q - AW'(1);
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    BUSY  = (state_q == SHIFT);
    DONE  = (state_q == FINISH);
    Y     = y_q;
    CARRY = carry_q;
  end

endmodule
